// File: rtl/mio_arbiter.sv
// Two-port MIO bus arbiter: one transaction at a time with a timeout abort.
// Define MIO_ARBITER_RR_EN for round-robin arbitration; the default is fixed priority (port 0 wins).
module mio_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic        bus_valid,
    output logic        bus_mem_w,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        owner,
    output logic        busy
);

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        winner;

`ifdef MIO_ARBITER_RR_EN
    logic last_q, last_d;

    // On a tie the port not served last wins.
    always_comb begin
        if (m0_req && m1_req) begin
            winner = ~last_q;
        end else begin
            winner = m1_req;
        end
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == StIdle && (m0_req || m1_req)) begin
            last_d = winner;
        end
    end
`else
    always_comb begin
        winner = ~m0_req;
    end
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    state_d = StAccess;
                    owner_d = winner;
                    we_d    = winner ? m1_we    : m0_we;
                    addr_d  = winner ? m1_addr  : m0_addr;
                    wdata_d = winner ? m1_wdata : m0_wdata;
                    cnt_d   = 8'd0;
                end
            end
            StAccess: begin
                // An ack arriving on the last allowed cycle still counts as success.
                if (bus_ack) begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    if (owner_q) begin
                        rdata1_d = bus_rdata;
                    end else begin
                        rdata0_d = bus_rdata;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            cnt_q    <= 8'd0;
            err_q    <= 1'b0;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Address and data come from the latched registers, so they hold outside ACCESS.
    always_comb begin
        bus_valid = (state_q == StAccess);
        bus_mem_w = (state_q == StAccess) && we_q;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        m0_done   = (state_q == StResp) && !owner_q;
        m1_done   = (state_q == StResp) && owner_q;
        m0_err    = m0_done && err_q;
        m1_err    = m1_done && err_q;
        m0_rdata  = rdata0_q;
        m1_rdata  = rdata1_q;
        owner     = owner_q;
        busy      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_mio_arbiter.sv
// Bench for mio_arbiter: directed cases plus randomized transactions checked against a
// transaction-level model (winner choice, expected latency, per-port read data).
module tb_mio_arbiter;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        RSTN;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_done, m0_err, m1_done, m1_err;
    logic        bus_valid, bus_mem_w, bus_ack, owner, busy;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_rdata [2];
    bit          last_served;
    bit          rr_mode;

    mio_arbiter #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .RSTN      (RSTN),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rdata  (m0_rdata),
        .m0_done   (m0_done),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rdata  (m1_rdata),
        .m1_done   (m1_done),
        .m1_err    (m1_err),
        .bus_valid (bus_valid),
        .bus_mem_w (bus_mem_w),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Policy model: a lone requester wins; on a tie fixed priority picks 0,
    // round-robin picks the port that was not served last.
    function automatic bit pick(input bit r0, input bit r1);
        if (r0 && r1) return rr_mode ? !last_served : 1'b0;
        return r1 && !r0;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
    task automatic run_txn(input bit r0, input bit r1, input bit we0, input bit we1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input int ack_delay, input logic [31:0] rd, input bit hold);
        bit          w, ew, exp_err;
        int          n_access;
        logic [31:0] ea, ed;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(bus_valid), 32'd0);
        chk("idle_done", {30'd0, m1_done, m0_done}, 32'd0);
        m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        w  = pick(r0, r1);
        last_served = w;
        ew = w ? we1 : we0;
        ea = w ? a1 : a0;
        ed = w ? d1 : d0;
        exp_err  = (ack_delay >= int'(TO));
        n_access = exp_err ? int'(TO) : ack_delay + 1;
        @(negedge clk);
        for (int j = 0; j < n_access; j++) begin
            chk("acc_valid", 32'(bus_valid), 32'd1);
            chk("acc_mem_w", 32'(bus_mem_w), 32'(ew));
            chk("acc_addr", bus_addr, ea);
            chk("acc_wdata", bus_wdata, ed);
            chk("acc_owner", 32'(owner), 32'(w));
            chk("acc_done", {30'd0, m1_done, m0_done}, 32'd0);
            if (!hold) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            m0_addr = $urandom; m1_addr = $urandom; m0_wdata = $urandom; m1_wdata = $urandom;
            m0_we = 1'($urandom); m1_we = 1'($urandom);
            bus_ack = (j == ack_delay);
            // A write's ack carries the port's current read data so rdata stays put either way.
            bus_rdata = ew ? exp_rdata[w] : rd;
            @(negedge clk);
        end
        if (!exp_err && !ew) exp_rdata[w] = rd;
        chk("resp_done", {30'd0, m1_done, m0_done}, w ? 32'd2 : 32'd1);
        chk("resp_err", 32'(w ? m1_err : m0_err), 32'(exp_err));
        chk("resp_rdata0", m0_rdata, exp_rdata[0]);
        chk("resp_rdata1", m1_rdata, exp_rdata[1]);
        chk("resp_valid", 32'(bus_valid), 32'd0);
        chk("resp_mem_w", 32'(bus_mem_w), 32'd0);
        chk("resp_addr_hold", bus_addr, ea);
        chk("resp_busy", 32'(busy), 32'd1);
        m0_req = 1'b0; m1_req = 1'b0;
        bus_ack = 1'($urandom); bus_rdata = $urandom;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("post_rdata0", m0_rdata, exp_rdata[0]);
        chk("post_rdata1", m1_rdata, exp_rdata[1]);
    endtask

    initial begin
        bit w;
        logic [31:0] rd;
        int r, dly;
`ifdef MIO_ARBITER_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif
        last_served  = 1'b1;
        exp_rdata[0] = 32'd0;
        exp_rdata[1] = 32'd0;
        RSTN = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        bus_ack = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_rdata0", m0_rdata, 32'd0);
        chk("rst_rdata1", m1_rdata, 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_flags", {26'd0, bus_valid, bus_mem_w, m0_done, m0_err, m1_done, m1_err}, 32'd0);
        RSTN = 1'b1;

        // m0 read, immediate ack
        run_txn(1, 0, 0, 0, 32'h0000_0010, 32'h0, 32'h0, 32'h0, 0, 32'hDEAD_BEEF, 0);
        // m1 write
        run_txn(0, 1, 0, 1, 32'h0, 32'hE000_0000, 32'h0, 32'h1234_5678, 2, 32'h0, 0);
        // timeout on m0 read; rdata must survive
        run_txn(1, 0, 0, 0, 32'h0000_0020, 32'h0, 32'h0, 32'h0, 1000, 32'hBAD0_BAD0, 0);
        // ack on the final allowed cycle beats the timeout
        run_txn(0, 1, 0, 0, 32'h0, 32'h0000_0040, 32'h0, 32'h0, int'(TO) - 1, 32'hCAFE_F00D, 1);

        // Both ports held high: four back-to-back transactions at a 3-cycle period.
        m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
        m0_addr = 32'h100; m1_addr = 32'h200;
        for (int k = 0; k < 4; k++) begin
            chk("arb_idle", 32'(busy), 32'd0);
            w = pick(1, 1);
            last_served = w;
            @(negedge clk);
            chk("arb_owner", 32'(owner), 32'(w));
            chk("arb_valid", 32'(bus_valid), 32'd1);
            rd = $urandom;
            bus_ack = 1; bus_rdata = rd;
            @(negedge clk);
            exp_rdata[w] = rd;
            bus_ack = 0;
            chk("arb_done", {30'd0, m1_done, m0_done}, w ? 32'd2 : 32'd1);
            chk("arb_rdata", w ? m1_rdata : m0_rdata, rd);
            @(negedge clk);
        end
        m0_req = 0; m1_req = 0;
        @(negedge clk);

        // Reset during ACCESS: no done pulse, held request served afterwards.
        m0_req = 1; m0_addr = 32'h300;
        @(negedge clk);
        chk("rst_mid_valid_before", 32'(bus_valid), 32'd1);
        RSTN = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(bus_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rdata", m0_rdata | m1_rdata, 32'd0);
        exp_rdata[0] = 32'd0;
        exp_rdata[1] = 32'd0;
        last_served  = 1'b1;
        @(negedge clk);
        chk("rst_mid_done", {30'd0, m1_done, m0_done}, 32'd0);
        RSTN = 1'b1;
        run_txn(1, 0, 0, 0, 32'h300, 32'h0, 32'h0, 32'h0, 1, 32'h5A5A_A5A5, 1);

        for (int n = 0; n < 40; n++) begin
            r   = $urandom_range(1, 3);
            dly = ($urandom_range(0, 4) == 0) ? $urandom_range(TO - 2, TO + 2)
                                               : $urandom_range(0, 4);
            run_txn(r[0], r[1], 1'($urandom), 1'($urandom), $urandom, $urandom,
                    $urandom, $urandom, dly, $urandom, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
